// File: rtl/ifft_post_cp.sv
// Transform-core output post-processor: optional conjugate + rounded 1/N scaling,
// ping-pong symbol buffering and cyclic-prefix insertion with sop/eop framing.
module ifft_post_cp #(
  parameter int W     = 11,
  parameter int LOG2N = 6,
  parameter int CP    = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inv,
  input  logic         valid_i,
  input  logic [W-1:0] xr_i,
  input  logic [W-1:0] xi_i,
  output logic         valid_o,
  output logic         sop_o,
  output logic         eop_o,
  output logic [W-1:0] yr_o,
  output logic [W-1:0] yi_o,
  output logic         ovf_o
);
  localparam int N          = 1 << LOG2N;
  localparam int CP_START_I = (N - CP) % N;
  localparam int RND_I      = 1 << (LOG2N - 1);
  localparam logic [LOG2N-1:0] LAST_IDX = '1;
  localparam logic [LOG2N-1:0] CP_START = CP_START_I[LOG2N-1:0];
  localparam logic signed [W:0] RND     = RND_I[W:0];
  localparam bit HAS_CP = (CP != 0);

  typedef enum logic [1:0] {IDLE, CPOUT, DATA} state_t;
  localparam state_t START_ST = HAS_CP ? CPOUT : DATA;

  logic [LOG2N-1:0] wr_idx_reg;
  logic             wb_reg, inv_reg, drop_reg, ovf_reg;
  logic [1:0]       full_reg;
  logic             rb_reg, rb_next;
  logic             free_now;
  logic             sym_start, drop_start, drop_cur, inv_cur, wr_en, wr_done;

  // A bank released by the reader in this very cycle counts as empty.
  assign sym_start  = valid_i && (wr_idx_reg == '0);
  assign drop_start = full_reg[wb_reg] && !(free_now && (rb_reg == wb_reg));
  assign drop_cur   = sym_start ? drop_start : drop_reg;
  assign inv_cur    = sym_start ? inv : inv_reg;
  assign wr_en      = valid_i && !drop_cur;
  assign wr_done    = wr_en && (wr_idx_reg == LAST_IDX);

  logic signed [W:0] xr_ext, xi_neg, xr_sum, xi_sum, xr_sh, xi_sh;
  logic [W-1:0]      yr_proc, yi_proc;
  logic              unused_bits;

  // One extra bit so that negating the most negative input cannot wrap.
  always_comb begin
    xr_ext  = {xr_i[W-1], xr_i};
    xi_neg  = -{xi_i[W-1], xi_i};
    xr_sum  = xr_ext + RND;
    xi_sum  = xi_neg + RND;
    xr_sh   = xr_sum >>> LOG2N;
    xi_sh   = xi_sum >>> LOG2N;
    yr_proc = inv_cur ? xr_sh[W-1:0] : xr_i;
    yi_proc = inv_cur ? xi_sh[W-1:0] : xi_i;
  end
  assign unused_bits = ^{xr_sh[W], xi_sh[W]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_idx_reg <= '0;
      wb_reg     <= 1'b0;
      inv_reg    <= 1'b0;
      drop_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (valid_i) begin
      wr_idx_reg <= wr_idx_reg + 1'b1;
      if (sym_start) begin
        inv_reg  <= inv;
        drop_reg <= drop_start;
        if (drop_start) ovf_reg <= 1'b1;
      end
      if (wr_done) wb_reg <= ~wb_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic full_q;
      always_ff @(posedge CLK) begin
        if (RST)                                 full_q <= 1'b0;
        else if (wr_done && (wb_reg == 1'(gi)))  full_q <= 1'b1;
        else if (free_now && (rb_reg == 1'(gi))) full_q <= 1'b0;
      end
      assign full_reg[gi] = full_q;
    end
  endgenerate

  logic [2*W-1:0] mem [0:2*N-1];
  logic [2*W-1:0] rd_data_reg;
  logic           rd_en;
  logic [LOG2N-1:0] rd_addr;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[{wb_reg, wr_idx_reg}] <= {yr_proc, yi_proc};
  end

  always_ff @(posedge CLK) begin
    if (RST)        rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[{rb_reg, rd_addr}];
  end

  state_t           state_reg, state_next;
  logic [LOG2N-1:0] rd_addr_reg, rd_addr_next;
  logic             in_cp, sop_next, eop_next;
  logic             valid_reg, sop_reg, eop_reg;

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    rb_next      = rb_reg;
    rd_en        = 1'b0;
    rd_addr      = rd_addr_reg;
    in_cp        = 1'b0;
    sop_next     = 1'b0;
    eop_next     = 1'b0;
    free_now     = 1'b0;
    case (state_reg)
      IDLE: if (full_reg[rb_reg]) begin
        rd_en   = 1'b1;
        rd_addr = CP_START;
        in_cp   = HAS_CP;
      end
      CPOUT: begin
        rd_en = 1'b1;
        in_cp = 1'b1;
      end
      DATA:    rd_en = 1'b1;
      default: state_next = IDLE;
    endcase
    if (rd_en) begin
      sop_next = HAS_CP ? (in_cp && (rd_addr == CP_START)) : (rd_addr == '0);
      if (in_cp) begin
        state_next   = (rd_addr == LAST_IDX) ? DATA : CPOUT;
        rd_addr_next = rd_addr + 1'b1;
      end else if (rd_addr == LAST_IDX) begin
        eop_next = 1'b1;
        free_now = 1'b1;
        rb_next  = ~rb_reg;
        // Chain straight into the other bank so back-to-back symbols leave no gap.
        if (full_reg[~rb_reg]) begin
          state_next   = START_ST;
          rd_addr_next = CP_START;
        end else begin
          state_next   = IDLE;
          rd_addr_next = '0;
        end
      end else begin
        state_next   = DATA;
        rd_addr_next = rd_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
      rb_reg      <= 1'b0;
      valid_reg   <= 1'b0;
      sop_reg     <= 1'b0;
      eop_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_addr_reg <= rd_addr_next;
      rb_reg      <= rb_next;
      valid_reg   <= rd_en;
      sop_reg     <= sop_next;
      eop_reg     <= eop_next;
    end
  end

  assign valid_o = valid_reg;
  assign sop_o   = sop_reg;
  assign eop_o   = eop_reg;
  assign yr_o    = rd_data_reg[2*W-1:W];
  assign yi_o    = rd_data_reg[W-1:0];
  assign ovf_o   = ovf_reg;
endmodule

// File: tb/tb_ifft_post_cp.sv
// Randomised bench for ifft_post_cp: a symbol-level scheduling/arithmetic model
// predicts every output cycle; a compare process checks the DUT each cycle.
module tb_ifft_post_cp;
  localparam int W = 11, LOG2N = 6, CP = 16;
  localparam int N = 1 << LOG2N, L = N + CP, HALF = N / 2;
  localparam int NONE = 32'h7fffffff;

  logic CLK = 1'b0, RST = 1'b1, inv = 1'b0, valid_i = 1'b0;
  logic [W-1:0] xr_i = '0, xi_i = '0;
  logic valid_o, sop_o, eop_o, ovf_o;
  logic [W-1:0] yr_o, yi_o;

  ifft_post_cp #(.W(W), .LOG2N(LOG2N), .CP(CP)) dut (
    .CLK(CLK), .RST(RST), .inv(inv), .valid_i(valid_i), .xr_i(xr_i), .xi_i(xi_i),
    .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .yr_o(yr_o), .yi_o(yi_o), .ovf_o(ovf_o)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int yr; int yi; bit sop; bit eop; } exp_t;
  exp_t exp_q[$];
  int   acc_eop[$];
  int   in_pos = 0, last_eop = -1000, ovf_cyc = NONE, last_in_cyc = 0, last_start = 0;
  bit   cur_inv, cur_drop;
  int   pr[N], pim[N];

  function automatic int floor_div(int a, int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic void model_reset(int c);
    in_pos = 0;
    acc_eop.delete();
    last_eop = -1000;
    ovf_cyc = NONE;
    while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
  endfunction

  function automatic void model_step(int c, bit r, bit v, int xr, int xi, bit iv);
    exp_t e;
    int s, idx;
    if (r) begin model_reset(c); return; end
    if (!v) return;
    if (in_pos == 0) begin
      cur_inv  = iv;
      // the bank this symbol needs was last used two accepted symbols ago
      cur_drop = (acc_eop.size() >= 2) && (acc_eop[acc_eop.size()-2] > c + 1);
      if (cur_drop && ovf_cyc == NONE) ovf_cyc = c;
    end
    if (cur_inv) begin
      pr[in_pos]  = floor_div(xr + HALF, N);
      pim[in_pos] = floor_div(-xi + HALF, N);
    end else begin
      pr[in_pos]  = xr;
      pim[in_pos] = xi;
    end
    if (in_pos == N - 1) begin
      last_in_cyc = c;
      if (!cur_drop) begin
        s = (c + 2 > last_eop + 1) ? c + 2 : last_eop + 1;
        for (int j = 0; j < L; j++) begin
          idx   = (j < CP) ? N - CP + j : j - CP;
          e.cyc = s + j; e.yr = pr[idx]; e.yi = pim[idx];
          e.sop = (j == 0); e.eop = (j == L - 1);
          exp_q.push_back(e);
        end
        last_eop = s + L - 1;
        last_start = s;
        acc_eop.push_back(last_eop);
      end
    end
    in_pos = (in_pos + 1) % N;
  endfunction

  // ---------------- stimulus helpers ----------------
  int sxr[N], sxi[N];
  bit sinv[N];

  function automatic int rnd_s();
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  function automatic void fill_random(bit iv);
    for (int k = 0; k < N; k++) begin
      sxr[k] = rnd_s(); sxi[k] = rnd_s(); sinv[k] = iv;
    end
  endfunction

  task automatic step(bit r, bit v, int xr, int xi, bit iv);
    @(negedge CLK); #1;
    RST = r; valid_i = v; xr_i = xr[W-1:0]; xi_i = xi[W-1:0]; inv = iv;
    model_step(cyc, r, v, xr, xi, iv);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic send_sym(int gap_pct);
    for (int k = 0; k < N; k++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      step(1'b0, 1'b1, sxr[k], sxi[k], sinv[k]);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int sop_seen = 0, last_sop_cyc = -1, vcnt = 0;
  int dut_yr[N], dut_yi[N];

  initial begin
    exp_t e;
    int c;
    bit exp_v;
    wait (cmp_en);
    forever begin
      @(negedge CLK);
      c = cyc;
      while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
        check("sched", exp_q[0].cyc, c);
        void'(exp_q.pop_front());
      end
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == c);
      check("valid_o", int'(valid_o), int'(exp_v));
      if (exp_v) begin
        e = exp_q.pop_front();
        check("yr_o", $signed(yr_o), e.yr);
        check("yi_o", $signed(yi_o), e.yi);
        check("sop_eop", {sop_o, eop_o}, {e.sop, e.eop});
      end else begin
        check("sop_eop_idle", {sop_o, eop_o}, 0);
      end
      check("ovf_o", int'(ovf_o), int'(c > ovf_cyc));
      if (valid_o) begin
        if (sop_o) begin sop_seen++; last_sop_cyc = c; vcnt = 0; end
        if (vcnt >= CP && vcnt < L) begin
          dut_yr[vcnt-CP] = $signed(yr_o);
          dut_yi[vcnt-CP] = $signed(yi_o);
        end
        vcnt++;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int s0, target;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i % 2) == 0, rnd_s(), rnd_s(), 1'b1);
      if (i == 0) cmp_en = 1;
    end
    idle(2);
    check("yr_o_reset", int'(yr_o), 0);
    check("yi_o_reset", int'(yi_o), 0);

    // IFFT ramp: xr=16k, xi=-16k
    for (int k = 0; k < N; k++) begin sxr[k] = 16 * k; sxi[k] = -16 * k; sinv[k] = 1; end
    send_sym(0);
    idle(L + 10);
    check("ramp_latency", last_sop_cyc - last_in_cyc, 2);
    check("ramp_sop_count", sop_seen, 1);
    check("ramp_y48", dut_yr[48], 12);
    check("ramp_y63", dut_yi[63], 16);
    check("ramp_y2", dut_yr[2], 1);

    // rounding edges
    fill_random(1'b1);
    sxr[0] = 32; sxr[1] = 31; sxr[2] = -32; sxr[3] = -33;
    sxr[4] = -1024; sxi[4] = -1024; sxi[5] = 1023;
    send_sym(0);
    idle(L + 10);
    check("rnd_32", dut_yr[0], 1);
    check("rnd_31", dut_yr[1], 0);
    check("rnd_m32", dut_yr[2], 0);
    check("rnd_m33", dut_yr[3], -1);
    check("rnd_m1024_r", dut_yr[4], -16);
    check("rnd_m1024_i", dut_yi[4], 16);
    check("rnd_1023_i", dut_yi[5], -16);

    // FFT pass-through, then inv toggled mid-symbol, then a scaled symbol
    fill_random(1'b0);
    send_sym(0);
    idle(L + 10);
    check("fft_pass", dut_yr[17], sxr[17]);
    fill_random(1'b0);
    for (int k = 10; k < N; k++) sinv[k] = 1;
    send_sym(0);
    idle(L + 10);
    check("toggle_pass", dut_yi[40], sxi[40]);
    fill_random(1'b1);
    send_sym(0);
    idle(L + 10);

    // sustained throughput: one symbol every N+CP cycles
    s0 = sop_seen;
    for (int i = 0; i < 4; i++) begin
      fill_random(1'($urandom_range(0, 1)));
      send_sym(0);
      idle(CP);
    end
    idle(L + 10);
    check("tp_sops", sop_seen - s0, 4);
    check("tp_ovf", int'(ovf_o), 0);

    // three symbols back to back: third is dropped
    s0 = sop_seen;
    for (int i = 0; i < 3; i++) begin fill_random(1'b1); send_sym(0); end
    idle(2 * L + 20);
    check("ovf_sops", sop_seen - s0, 2);
    check("ovf_sticky", int'(ovf_o), 1);

    // random symbols with gaps and random spacing
    for (int i = 0; i < 6; i++) begin
      fill_random(1'($urandom_range(0, 1)));
      send_sym(10);
      idle($urandom_range(0, 40));
    end
    idle(2 * L + 20);

    // reset during output sample 30
    fill_random(1'b1);
    send_sym(0);
    target = last_start + 30;
    while (cyc + 1 < target) idle(1);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("rst_mid_valid", int'(valid_o), 0);
    check("rst_mid_ovf", int'(ovf_o), 0);

    // fresh symbol after reset
    s0 = sop_seen;
    fill_random(1'b1);
    send_sym(0);
    idle(L + 10);
    check("fresh_latency", last_sop_cyc - last_in_cyc, 2);
    check("fresh_sops", sop_seen - s0, 1);

    for (int i = 0; i < 500 && exp_q.size() > 0; i++) idle(1);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifft_post_cp.md
# ifft_post_cp

Post-processing stage for the OFDM modulator's transform core. It consumes the core's raw, natural-order complex output stream and, in IFFT mode, applies output conjugation and rounded 1/N scaling; in FFT mode it passes samples through unchanged. Each symbol is stored in a ping-pong buffer and re-emitted with a cyclic prefix (CP) and start/end-of-symbol flags. It sits between the transform core and the DAC/framing path. It replaces the fixed 64-point, truncating, prefix-less conjugate/scale wrapper with a parametrised block.

## Interface
Parameters:
- W, 11, signed sample width (input and output, per component)
- LOG2N, 6, log2 of transform length N (N = 2^LOG2N)
- CP, 16, cyclic-prefix length in samples; legal range 0..N-1

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- inv  in  1  1 = IFFT mode (conjugate + scale), 0 = FFT mode (pass-through); sampled per symbol
- valid_i  in  1  input sample strobe from core
- xr_i, xi_i  in  W each  signed real/imag input sample, natural order
- valid_o  out  1  output sample valid
- sop_o  out  1  first output sample of a symbol (first CP sample, or sample 0 if CP=0)
- eop_o  out  1  last output sample of a symbol (sample N-1)
- yr_o, yi_o  out  W each  signed real/imag output sample
- ovf_o  out  1  sticky: an input symbol was dropped

## Operation
- Write side: counter wr_idx (0..N-1) and bank pointer wb. Each valid_i writes the processed sample to bank wb at address wr_idx. wr_idx wraps N-1 -> 0. On wrap, bank wb is marked full and wb toggles.
- inv is latched when valid_i arrives with wr_idx==0. A change of inv mid-symbol has no effect until the next symbol.
- IFFT processing: yr = (xr + 2^(LOG2N-1)) >>> LOG2N, and yi = (-xi + 2^(LOG2N-1)) >>> LOG2N. The rounding is half-up. Negation and addition are done in W+1 bits, so -(-2^(W-1)) does not overflow. The result always fits in W bits, so no saturation is needed. Upstream input conjugation is outside this block.
- FFT processing: the sample is stored unchanged.
- Drop rule: if valid_i arrives with wr_idx==0 while bank wb is still full, the whole symbol (N samples) is discarded. wr_idx still counts, no bank is marked full, and ovf_o is set. ovf_o clears only on RST.
- Read side FSM:
  - IDLE: if the bank at rb is full, go to CPOUT (or DATA if CP=0) and set the read address to N-CP (or 0).
  - CPOUT: emits addresses N-CP..N-1, then goes to DATA at address 0.
  - DATA: emits addresses 0..N-1. After N-1, bank rb is freed and rb toggles. If the new rb bank is already full, the FSM restarts directly, so the next symbol's sop_o follows eop_o with no gap. Otherwise it goes to IDLE.
- Simultaneous events:
  - If a bank is freed in the same cycle that a new symbol starts writing into it, the free wins and the symbol is accepted.
  - If the last write and the read start hit the same bank, the full flag is registered first; there is no bypass.
- Buffer: 2×N entries of 2W bits. RAM read is synchronous (registered).

## Timing
- Reset values: valid_o=0, sop_o=0, eop_o=0, yr_o=0, yi_o=0, ovf_o=0. RST also sets wr_idx=0, wb=rb=0, both banks empty and FSM=IDLE. In-flight symbols are discarded.
- Latency: last input sample accepted at cycle t -> bank full at t+1 -> sop_o/valid_o at t+2.
- valid_o is high for exactly N+CP consecutive cycles per symbol. sop_o and eop_o are single-cycle pulses coincident with valid_o. When CP=0 and N=1 is excluded, sop_o and eop_o never coincide.
- Sustained loss-free input: on average, no more than one symbol per N+CP cycles. Up to one symbol of burst is absorbed.
- RST asserted mid-readout: valid_o=0 from the next cycle.

## Test plan
- Reset: hold RST 3 cycles with valid_i toggling -> all outputs 0. No valid_o until a full symbol is written after reset.
- IFFT symbol (N=64, CP=16, inv=1): input 64 consecutive samples xr=16k, xi=-16k for k=0..63. Required response:
  - yr=yi=(16k+32)>>>6.
  - Output order is k=48..63 then k=0..63, over 80 contiguous valid_o cycles.
  - sop_o is on k=48, eop_o on the final k=63.
  - sop_o arrives 2 cycles after the last input.
- Rounding edges (inv=1):
  - xr=32 -> 1; xr=31 -> 0; xr=-32 -> 0; xr=-33 -> -1.
  - xr=-1024, xi=-1024 -> yr=-16, yi=16.
  - xi=1023 -> yi=-16.
- FFT pass-through: inv=0, random samples -> output identical to input, with CP prepended. Toggle inv to 1 at k=10 -> the symbol stays pass-through; the next symbol is scaled.
- Throughput and overflow:
  - Symbols spaced 80 cycles apart -> valid_o continuous, ovf_o=0.
  - Three symbols back-to-back, 64 cycles apart -> symbols 1 and 2 are output; symbol 3 is dropped and ovf_o=1, staying 1.
- Reset mid-output: assert RST at output sample 30 -> valid_o=0 next cycle and ovf_o=0. A fresh symbol afterward is output correctly with the 2-cycle latency.
